// File: rtl/arm_memory_arbiter.sv
// rtl/arm_memory_arbiter.sv - two-master round-robin arbiter with bus lock for a unified memory
//
// Purpose:
//   Shares one synchronous-read memory between master 0 (CPU) and master 1
//   (loader/DMA/debug). Every access runs IDLE -> ACCESS -> RESPOND. A master
//   holding Lock keeps the bus across accesses until it releases Lock or idles
//   past LockTimeout.
//
// Ports:
//   i_CLK, i_RESET                    clock, asynchronous active-high reset
//   i_Mx_Req/Write/Lock/Address/
//   i_Mx_WriteData                    master x request (x = 0, 1)
//   o_Mx_Ready, o_Mx_ReadData         master x completion pulse and read data
//   o_MemWrite, o_Address,
//   o_WriteData, i_ReadData           memory port (read data valid one cycle after address)
//   o_Owner                           current/last granted master
//   o_LockErr                         one-cycle pulse when a lock is forcibly released
module arm_memory_arbiter #(
  parameter int BusWidth    = 32,
  parameter int LockTimeout = 15
) (
  input  logic                i_CLK,
  input  logic                i_RESET,
  input  logic                i_M0_Req,
  input  logic                i_M0_Write,
  input  logic                i_M0_Lock,
  input  logic [BusWidth-1:0] i_M0_Address,
  input  logic [BusWidth-1:0] i_M0_WriteData,
  output logic                o_M0_Ready,
  output logic [BusWidth-1:0] o_M0_ReadData,
  input  logic                i_M1_Req,
  input  logic                i_M1_Write,
  input  logic                i_M1_Lock,
  input  logic [BusWidth-1:0] i_M1_Address,
  input  logic [BusWidth-1:0] i_M1_WriteData,
  output logic                o_M1_Ready,
  output logic [BusWidth-1:0] o_M1_ReadData,
  output logic                o_MemWrite,
  output logic [BusWidth-1:0] o_Address,
  output logic [BusWidth-1:0] o_WriteData,
  input  logic [BusWidth-1:0] i_ReadData,
  output logic                o_Owner,
  output logic                o_LockErr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  localparam int CntW = $clog2(LockTimeout);
  localparam logic [CntW-1:0] CntMax = CntW'(LockTimeout - 1);

  logic [1:0]      state;
  logic            owner;
  logic            last_owner;
  logic [CntW-1:0] lock_cnt;
  logic            lock_err;

  // Owner-side views, selected by the registered owner only.
  logic                own_req, own_write, own_lock, other_req;
  logic [BusWidth-1:0] own_addr, own_wdata;

  assign own_req   = owner ? i_M1_Req       : i_M0_Req;
  assign own_write = owner ? i_M1_Write     : i_M0_Write;
  assign own_lock  = owner ? i_M1_Lock      : i_M0_Lock;
  assign own_addr  = owner ? i_M1_Address   : i_M0_Address;
  assign own_wdata = owner ? i_M1_WriteData : i_M0_WriteData;
  assign other_req = owner ? i_M0_Req       : i_M1_Req;

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;   // so master 0 wins the first tie
      lock_cnt   <= '0;
      lock_err   <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_M0_Req && i_M1_Req) begin
            owner <= ~last_owner;
            state <= ACCESS;
          end else if (i_M0_Req) begin
            owner <= 1'b0;
            state <= ACCESS;
          end else if (i_M1_Req) begin
            owner <= 1'b1;
            state <= ACCESS;
          end
        end
        ACCESS: state <= RESPOND;
        RESPOND: begin
          // The owner's Req seen here still belongs to the access just completed.
          last_owner <= owner;
          if (own_lock) begin
            state    <= LOCKED;
            lock_cnt <= '0;
          end else if (other_req) begin
            owner <= ~owner;
            state <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        LOCKED: begin
          if (own_req) begin
            state <= ACCESS;
          end else if (!own_lock) begin
            state <= IDLE;
          end else if (lock_cnt == CntMax) begin
            state    <= IDLE;
            lock_err <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + CntW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic in_access, in_respond;
  assign in_access  = (state == ACCESS);
  assign in_respond = (state == RESPOND);

  // Decoded from state so the write strobe falls the instant reset asserts.
  assign o_MemWrite  = in_access & own_write;
  assign o_Address   = in_access ? own_addr  : '0;
  assign o_WriteData = in_access ? own_wdata : '0;

  assign o_M0_Ready    = in_respond & ~owner;
  assign o_M1_Ready    = in_respond & owner;
  assign o_M0_ReadData = o_M0_Ready ? i_ReadData : '0;
  assign o_M1_ReadData = o_M1_Ready ? i_ReadData : '0;

  assign o_Owner   = owner;
  assign o_LockErr = lock_err;

endmodule
